blink_rate_ctrl: RTL and testbench
==================================

BLINK_RATE_CTRL -- requirements
Module: blink_rate_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, the stable-input cycles required to accept a button change (10 ms at 25 MHz).
REQ-002 The block SHALL have parameters PERIOD0..PERIOD3, defaults 6000001, 12500000, 3125000 and 25000000, the tick period in clock cycles for rate_sel 0..3.
REQ-003 The block SHALL have port CLK25, input, 1 bit: the 25 MHz board clock and the only clock.
REQ-004 The block SHALL have port RSTN, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port btn_n, input, 1 bit: raw push-button, active-low, asynchronous to CLK25.
REQ-006 The block SHALL have port en, input, 1 bit: tick generation enable.
REQ-007 The block SHALL have port tick, output, 1 bit: a one-cycle strobe that the downstream blinker consumes as its toggle event.
REQ-008 The block SHALL have port rate_sel, output, 2 bits: the currently selected rate index.
REQ-009 The block SHALL have port btn_level, output, 1 bit: the debounced button state, 1 = pressed.
REQ-010 The block SHALL have port press, output, 1 bit: a one-cycle strobe on each accepted press.

Function
REQ-011 btn_n SHALL pass through a two-flop synchronizer before any other logic; the synchronizer adds 2 cycles of latency.
REQ-012 The debouncer SHALL be a four-state FSM:
- UP: on synchronized press, go to CHK_DN and clear the counter.
- CHK_DN: on input release, return to UP; when the counter reaches DEBOUNCE_CYCLES-1, go to DOWN.
- DOWN: on synchronized release, go to CHK_UP and clear the counter.
- CHK_UP: on input press, return to DOWN; when the counter reaches DEBOUNCE_CYCLES-1, go to UP.
REQ-013 btn_level SHALL be 1 in DOWN and CHK_UP, and 0 in UP and CHK_DN.
REQ-014 press SHALL pulse for exactly one cycle on the CHK_DN->DOWN transition. There is no pulse on release.
REQ-015 Each press SHALL advance rate_sel by 1 modulo 4, wrapping 3->0.
REQ-016 The period counter SHALL be 25 bits wide, count 0..PERIOD[rate_sel]-1, and assert tick for one cycle in the cycle it wraps to 0.
REQ-017 With en=1 and no rate change, consecutive ticks SHALL be exactly PERIOD[rate_sel] cycles apart.
REQ-018 In a cycle where press=1, the period counter SHALL clear to 0 and tick SHALL stay 0, even if the counter was at its terminal count; the rate change wins.
REQ-019 The first tick after a rate change SHALL occur PERIOD[new rate] cycles after the press cycle.
REQ-020 While en=0, the period counter SHALL hold at 0 and tick SHALL be 0. Debounce and rate_sel SHALL keep operating.
REQ-021 When en rises, the first tick SHALL occur PERIOD[rate_sel] cycles after the first cycle with en=1.
REQ-022 tick, press, rate_sel and btn_level SHALL all be registered outputs.

Reset
REQ-023 While RSTN=0, all flops SHALL take their reset values immediately, independent of CLK25.
REQ-024 Reset values SHALL be: tick=0, press=0, btn_level=0, rate_sel=0, FSM=UP, both counters=0, synchronizer flops=1 (button released).
REQ-025 A reset asserted mid-debounce or mid-period SHALL abandon that operation with no tick or press pulse.
REQ-026 Reset deassertion SHALL be synchronized externally. After release, the first tick SHALL occur PERIOD0 cycles later if en=1.

Structure
REQ-027 Shared package pl_blink_pkg SHALL hold:
- the PERIOD0..3 default constants;
- the counter width constant (25);
- the debounce FSM state encoding.
REQ-028 Debounce SHALL be a sub-module btn_debounce, containing the synchronizer, FSM, btn_level and press. The rate/tick logic SHALL stay in blink_rate_ctrl.

Verification (DEBOUNCE_CYCLES=4, PERIOD0..3 = 5,7,3,10)
REQ-029 Scenario: reset released, en=1, btn_n=1 held -> tick pulses at cycles 5, 10, 15; rate_sel=0; press never asserted.
REQ-030 Scenario: btn_n pulled low 3 cycles, then high -> no press pulse, btn_level stays 0, rate_sel unchanged.
REQ-031 Scenario: btn_n low 20 cycles -> a single press pulse and rate_sel=1. Ticks then run 7 cycles apart, with no tick in the press cycle.
REQ-032 Scenario: four accepted presses -> rate_sel steps 1, 2, 3, 0. A press landing on a terminal-count cycle produces no tick.
REQ-033 Scenario: en=0 for 30 cycles -> no ticks. After en rises, the first tick comes exactly PERIOD[rate_sel] cycles later.
REQ-034 Scenario: RSTN pulsed low mid-period with rate_sel=2 -> outputs clear asynchronously, rate_sel=0, and the next tick comes 5 cycles after release.

Source files
------------

// File: rtl/pl_blink_pkg.sv
// Shared constants for the blink rate controller:
// default tick periods, counter width, debounce state encoding.
package pl_blink_pkg;

  localparam int CNT_W = 25;

  localparam int PERIOD0_DEF = 6000001;
  localparam int PERIOD1_DEF = 12500000;
  localparam int PERIOD2_DEF = 3125000;
  localparam int PERIOD3_DEF = 25000000;

  localparam logic [1:0] ST_UP     = 2'd0;
  localparam logic [1:0] ST_CHK_DN = 2'd1;
  localparam logic [1:0] ST_DOWN   = 2'd2;
  localparam logic [1:0] ST_CHK_UP = 2'd3;

  function automatic logic st_pressed(
    input logic [1:0] st
  );
    return (st == ST_DOWN) || (st == ST_CHK_UP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and four-state debouncer.
// Emits the debounced level and a one-cycle press strobe.
module btn_debounce
  import pl_blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic CLK25,
  input  logic RSTN,
  input  logic btn_n,
  output logic btn_level,
  output logic press,
  output logic press_nxt
);

  localparam int DW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] TERM =
    DW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          dn;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;
  logic          done;

  assign dn   = ~sync2;
  assign done = (cnt == TERM);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press_nxt = 1'b0;
    unique case (state)
      ST_UP: begin
        if (dn) begin
          state_nxt = ST_CHK_DN;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_DN: begin
        if (!dn) begin
          state_nxt = ST_UP;
        end else if (done) begin
          state_nxt = ST_DOWN;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_DOWN: begin
        if (!dn) begin
          state_nxt = ST_CHK_UP;
          cnt_nxt   = '0;
        end
      end
      ST_CHK_UP: begin
        if (dn) begin
          state_nxt = ST_DOWN;
        end else if (done) begin
          state_nxt = ST_UP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  // Sync flops reset to 1 so reset reads as released
  always_ff @(posedge CLK25 or negedge RSTN) begin
    if (!RSTN) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      state     <= ST_UP;
      cnt       <= '0;
      btn_level <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync1     <= btn_n;
      sync2     <= sync1;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= st_pressed(state_nxt);
      press     <= press_nxt;
    end
  end

endmodule

// File: rtl/blink_rate_ctrl.sv
// Button-selectable tick generator: four periods,
// cycled by debounced presses, gated by en.
module blink_rate_ctrl
  import pl_blink_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PERIOD0 = PERIOD0_DEF,
  parameter int PERIOD1 = PERIOD1_DEF,
  parameter int PERIOD2 = PERIOD2_DEF,
  parameter int PERIOD3 = PERIOD3_DEF
) (
  input  logic       CLK25,
  input  logic       RSTN,
  input  logic       btn_n,
  input  logic       en,
  output logic       tick,
  output logic [1:0] rate_sel,
  output logic       btn_level,
  output logic       press
);

  logic             press_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] term;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .CLK25    (CLK25),
    .RSTN     (RSTN),
    .btn_n    (btn_n),
    .btn_level(btn_level),
    .press    (press),
    .press_nxt(press_nxt)
  );

  always_comb begin
    term = '0;
    unique case (rate_sel)
      2'd0: term = CNT_W'(PERIOD0 - 1);
      2'd1: term = CNT_W'(PERIOD1 - 1);
      2'd2: term = CNT_W'(PERIOD2 - 1);
      2'd3: term = CNT_W'(PERIOD3 - 1);
    endcase
  end

  // A press lands together with its rate change, so it
  // suppresses any tick due in the same cycle.
  always_ff @(posedge CLK25 or negedge RSTN) begin
    if (!RSTN) begin
      cnt      <= '0;
      tick     <= 1'b0;
      rate_sel <= 2'd0;
    end else if (press_nxt) begin
      cnt      <= '0;
      tick     <= 1'b0;
      rate_sel <= rate_sel + 2'd1;
    end else if (!en) begin
      cnt      <= '0;
      tick     <= 1'b0;
    end else if (cnt == term) begin
      cnt      <= '0;
      tick     <= 1'b1;
    end else begin
      cnt      <= cnt + 1'b1;
      tick     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_blink_rate_ctrl.sv
// Self-checking bench for blink_rate_ctrl with a
// behavioural reference model and scripted scenarios.
module tb_blink_rate_ctrl;

  localparam int DEB = 4;

  logic       CLK25;
  logic       RSTN;
  logic       btn_n;
  logic       en;
  logic       tick;
  logic [1:0] rate_sel;
  logic       btn_level;
  logic       press;

  int tests  = 0;
  int failed = 0;

  blink_rate_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .PERIOD0(5),
    .PERIOD1(7),
    .PERIOD2(3),
    .PERIOD3(10)
  ) dut (
    .CLK25    (CLK25),
    .RSTN     (RSTN),
    .btn_n    (btn_n),
    .en       (en),
    .tick     (tick),
    .rate_sel (rate_sel),
    .btn_level(btn_level),
    .press    (press)
  );

  initial CLK25 = 1'b0;
  always #5 CLK25 = ~CLK25;

  // Reference model: debounced level flips once DEB+1
  // consecutive synced samples disagree with it; ticks
  // fall on multiples of the period from the last anchor
  // (reset, press, or cycle with en low).
  int   per [4] = '{5, 7, 3, 10};
  logic dq[$];
  int   m_j;
  int   m_a;
  int   m_rate;
  int   m_run;
  logic m_lvl;
  logic m_press;
  logic m_tick;

  int obs_ticks;
  int obs_press;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic model_reset();
    dq = '{1'b1, 1'b1};
    m_j = 0;
    m_a = 0;
    m_rate = 0;
    m_run = 0;
    m_lvl = 1'b0;
    m_press = 1'b0;
    m_tick = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic e);
    logic s;
    logic pressed_s;
    s = dq.pop_front();
    dq.push_back(b);
    m_j++;
    m_press = 1'b0;
    pressed_s = ~s;
    if (pressed_s != m_lvl) m_run++;
    else m_run = 0;
    if (m_run == DEB + 1) begin
      m_lvl = pressed_s;
      m_run = 0;
      m_press = pressed_s;
    end
    if (m_press) begin
      m_rate = (m_rate + 1) % 4;
      m_a = m_j;
      m_tick = 1'b0;
    end else if (!e) begin
      m_a = m_j;
      m_tick = 1'b0;
    end else begin
      m_tick = ((m_j - m_a) % per[m_rate]) == 0;
    end
  endtask

  // One clock: inputs applied at negedge, outputs checked
  // at the following negedge against the model.
  task automatic cyc(input logic b, input logic e);
    btn_n = b;
    en = e;
    @(posedge CLK25);
    model_step(b, e);
    @(negedge CLK25);
    if (tick) obs_ticks++;
    if (press) obs_press++;
    chk($sformatf("cycle %0d outputs", m_j),
        {27'd0, tick, press, rate_sel, btn_level},
        {27'd0, m_tick, m_press, m_rate[1:0], m_lvl});
  endtask

  typedef struct {
    logic       b;
    logic       e;
    int         n;
    int         ticks;
    int         presses;
    logic [1:0] rate;
    logic       lvl;
  } vec_t;

  vec_t vt[7];

  initial begin
    int   first;
    logic [1:0] exp_rate [4];

    vt[0] = '{1'b1, 1'b1, 15, 3, 0, 2'd0, 1'b0};
    vt[1] = '{1'b0, 1'b1,  3, 0, 0, 2'd0, 1'b0};
    vt[2] = '{1'b1, 1'b1, 10, 2, 0, 2'd0, 1'b0};
    vt[3] = '{1'b0, 1'b1, 20, 2, 1, 2'd1, 1'b1};
    vt[4] = '{1'b1, 1'b1, 16, 3, 0, 2'd1, 1'b0};
    vt[5] = '{1'b1, 1'b0, 30, 0, 0, 2'd1, 1'b0};
    vt[6] = '{1'b1, 1'b1,  7, 1, 0, 2'd1, 1'b0};

    RSTN = 1'b0;
    btn_n = 1'b1;
    en = 1'b1;
    repeat (3) @(negedge CLK25);
    chk("reset state",
        {28'd0, tick, press, rate_sel, btn_level}, 32'd0);
    RSTN = 1'b1;
    model_reset();

    for (int v = 0; v < 7; v++) begin
      obs_ticks = 0;
      obs_press = 0;
      for (int k = 0; k < vt[v].n; k++) cyc(vt[v].b, vt[v].e);
      chk($sformatf("row %0d ticks", v), obs_ticks, vt[v].ticks);
      chk($sformatf("row %0d presses", v), obs_press, vt[v].presses);
      chk($sformatf("row %0d rate_sel", v), rate_sel, vt[v].rate);
      chk($sformatf("row %0d btn_level", v), btn_level, vt[v].lvl);
    end

    // Press accepted exactly on a terminal-count cycle
    repeat (7) cyc(1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("terminal press {press,tick,rate}",
        {press, tick, rate_sel}, {1'b1, 1'b0, 2'd2});
    repeat (3) cyc(1'b0, 1'b1);
    repeat (12) cyc(1'b1, 1'b1);
    chk("rate before reset", rate_sel, 2'd2);

    // Reset mid-debounce and mid-period
    repeat (3) cyc(1'b0, 1'b1);
    #2 RSTN = 1'b0;
    #1;
    chk("async reset clears outputs",
        {28'd0, tick, press, rate_sel, btn_level}, 32'd0);
    @(posedge CLK25);
    @(posedge CLK25);
    @(negedge CLK25);
    chk("outputs held in reset",
        {28'd0, tick, press, rate_sel, btn_level}, 32'd0);
    RSTN = 1'b1;
    model_reset();
    obs_ticks = 0;
    obs_press = 0;
    first = -1;
    for (int k = 1; k <= 20 && first < 0; k++) begin
      cyc(1'b1, 1'b1);
      if (tick) first = k;
    end
    chk("first tick after reset", first, 5);
    chk("no press after reset", obs_press, 0);

    // Four accepted presses step the rate and wrap
    exp_rate = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int p = 0; p < 4; p++) begin
      repeat (10) cyc(1'b0, 1'b1);
      repeat (12) cyc(1'b1, 1'b1);
      chk($sformatf("press %0d rate_sel", p), rate_sel, exp_rate[p]);
    end

    // Randomized bouncing button and enable gating
    for (int tot = 0; tot < 3000;) begin
      logic b;
      logic e;
      int   len;
      b   = 1'($urandom_range(0, 1));
      e   = ($urandom_range(0, 7) != 0);
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) cyc(b, e);
      tot += len;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
